rd_ptr_empty_lvl: RTL and testbench

Read-side pointer and status block for the dual-clock FIFO, the parametrised successor to the plain read-pointer/empty generator. It owns the read binary and Gray pointers and synchronises the write Gray pointer into the read domain through a configurable number of flop stages. From these it produces the registered empty flag, a programmable almost-empty flag, and a fill-level count. It sits in the read clock domain between the FIFO RAM read port and the consumer; its Gray pointer feeds the write-side full logic.

---
 rtl/rd_ptr_empty_lvl.sv | 84 ++++++++
 tb/tb_rd_ptr_empty_lvl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rd_ptr_empty_lvl.sv
// Read-side pointer, synchronised write pointer, empty/almost-empty/level status for the dual-clock FIFO.
// Optional macro RD_PTR_UNDERFLOW_EN builds the registered rejected-read pulse on RD_UNDERFLOW.
module rd_ptr_empty_lvl #(
    parameter int C_ADDR_BITS   = 9,
    parameter int C_SYNC_STAGES = 2,
    parameter int C_AE_THRESH   = 4
) (
    input  logic                   RD_CLK,
    input  logic                   RD_RST,
    input  logic                   RD_EN,
    input  logic [C_ADDR_BITS:0]   WR_PTR_GRAY,
    output logic [C_ADDR_BITS-1:0] RD_ADDR,
    output logic [C_ADDR_BITS:0]   RD_PTR_GRAY,
    output logic                   RD_EMPTY,
    output logic                   RD_ALMOST_EMPTY,
    output logic [C_ADDR_BITS:0]   RD_LEVEL,
    output logic                   RD_UNDERFLOW
);
    localparam int PW = C_ADDR_BITS + 1;

    logic [PW-1:0] rBin;
    logic [PW-1:0] binNxt;
    logic [PW-1:0] grayNxt;
    logic [PW-1:0] wsyncGray;
    logic [PW-1:0] wsyncBin;
    logic [PW-1:0] levelNxt;
    logic [C_SYNC_STAGES-1:0][PW-1:0] syncPipe;
    logic accept;

    assign accept  = RD_EN & ~RD_EMPTY;
    assign binNxt  = rBin + PW'(accept);
    assign grayNxt = binNxt ^ (binNxt >> 1);
    // Next-pointer address so the synchronous RAM has the word ready one cycle after accept.
    assign RD_ADDR = binNxt[C_ADDR_BITS-1:0];

    always_ff @(posedge RD_CLK or posedge RD_RST) begin
        if (RD_RST) begin
            syncPipe <= '0;
        end else begin
            syncPipe <= {syncPipe[C_SYNC_STAGES-2:0], WR_PTR_GRAY};
        end
    end

    assign wsyncGray = syncPipe[C_SYNC_STAGES-1];

    always_comb begin
        wsyncBin = '0;
        for (int i = 0; i < PW; i++) begin
            wsyncBin[i] = ^(wsyncGray >> i);
        end
    end

    // Modulo subtraction yields 2^C_ADDR_BITS (MSB set) when full.
    assign levelNxt = wsyncBin - binNxt;

    always_ff @(posedge RD_CLK or posedge RD_RST) begin
        if (RD_RST) begin
            rBin            <= '0;
            RD_PTR_GRAY     <= '0;
            RD_EMPTY        <= 1'b1;
            RD_ALMOST_EMPTY <= 1'b1;
            RD_LEVEL        <= '0;
        end else begin
            rBin            <= binNxt;
            RD_PTR_GRAY     <= grayNxt;
            RD_EMPTY        <= (grayNxt == wsyncGray);
            RD_ALMOST_EMPTY <= (levelNxt <= PW'(C_AE_THRESH));
            RD_LEVEL        <= levelNxt;
        end
    end

`ifdef RD_PTR_UNDERFLOW_EN
    always_ff @(posedge RD_CLK or posedge RD_RST) begin
        if (RD_RST) begin
            RD_UNDERFLOW <= 1'b0;
        end else begin
            RD_UNDERFLOW <= RD_EN & RD_EMPTY;
        end
    end
`else
    assign RD_UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ptr_empty_lvl.sv
// Scoreboard bench for rd_ptr_empty_lvl: the driver queues expected outputs per cycle, a negedge monitor compares.
module tb_rd_ptr_empty_lvl;
    logic       RD_CLK = 1'b0;
    logic       RD_RST;
    logic       RD_EN;
    logic [9:0] WR_PTR_GRAY;
    logic [8:0] RD_ADDR;
    logic [9:0] RD_PTR_GRAY;
    logic       RD_EMPTY;
    logic       RD_ALMOST_EMPTY;
    logic [9:0] RD_LEVEL;
    logic       RD_UNDERFLOW;

    rd_ptr_empty_lvl #(.C_ADDR_BITS(9), .C_SYNC_STAGES(2), .C_AE_THRESH(4)) dut (
        .RD_CLK(RD_CLK), .RD_RST(RD_RST), .RD_EN(RD_EN), .WR_PTR_GRAY(WR_PTR_GRAY),
        .RD_ADDR(RD_ADDR), .RD_PTR_GRAY(RD_PTR_GRAY), .RD_EMPTY(RD_EMPTY),
        .RD_ALMOST_EMPTY(RD_ALMOST_EMPTY), .RD_LEVEL(RD_LEVEL), .RD_UNDERFLOW(RD_UNDERFLOW)
    );

    always #5 RD_CLK = ~RD_CLK;

    typedef struct {
        string      name;
        logic [9:0] level;
        logic       empty;
        logic       ae;
        logic [8:0] addr;
        logic [9:0] gray;
        logic       uf;
    } exp_t;

    exp_t sbQ[$];
    exp_t mon;
    int   nChecks = 0;
    int   nFails  = 0;

    function automatic logic [9:0] g(input int b);
        logic [9:0] v;
        v = 10'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic ufx(input logic b);
`ifdef RD_PTR_UNDERFLOW_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    // bin is the expected registered binary read pointer; RD_PTR_GRAY must be its Gray code.
    function automatic exp_t mk(input string n, input int lvl, input logic emp, input logic ae,
                                input int addr, input int bin, input logic uf);
        exp_t e;
        e.name  = n;
        e.level = 10'(lvl);
        e.empty = emp;
        e.ae    = ae;
        e.addr  = 9'(addr);
        e.gray  = g(bin);
        e.uf    = uf;
        return e;
    endfunction

    always @(negedge RD_CLK) begin
        if (sbQ.size() > 0) begin
            mon = sbQ.pop_front();
            nChecks++;
            if ({RD_LEVEL, RD_EMPTY, RD_ALMOST_EMPTY, RD_ADDR, RD_PTR_GRAY, RD_UNDERFLOW} !==
                {mon.level, mon.empty, mon.ae, mon.addr, mon.gray, mon.uf}) begin
                nFails++;
                $display("FAIL %s: got lvl=%0d emp=%b ae=%b addr=%0d gray=%h uf=%b, expected lvl=%0d emp=%b ae=%b addr=%0d gray=%h uf=%b",
                         mon.name, RD_LEVEL, RD_EMPTY, RD_ALMOST_EMPTY, RD_ADDR, RD_PTR_GRAY, RD_UNDERFLOW,
                         mon.level, mon.empty, mon.ae, mon.addr, mon.gray, mon.uf);
            end
        end
    end

    task automatic cyc(input logic rd, input logic [9:0] wg, input exp_t e);
        @(posedge RD_CLK);
        #1;
        RD_EN       = rd;
        WR_PTR_GRAY = wg;
        sbQ.push_back(e);
    endtask

    // Reset is raised mid-cycle and checked at the following negedge, before any clock edge.
    task automatic doReset();
        @(posedge RD_CLK);
        #1;
        RD_RST      = 1'b1;
        RD_EN       = 1'b0;
        WR_PTR_GRAY = '0;
        sbQ.push_back(mk("reset", 0, 1, 1, 0, 0, 0));
        @(posedge RD_CLK);
        #1;
        RD_RST = 1'b0;
    endtask

    initial begin
        RD_RST      = 1'b1;
        RD_EN       = 1'b0;
        WR_PTR_GRAY = '0;
        @(posedge RD_CLK);
        #1;
        sbQ.push_back(mk("reset_init", 0, 1, 1, 0, 0, 0));
        @(posedge RD_CLK);
        #1;
        RD_RST = 1'b0;

        // Reads on an empty FIFO are rejected.
        for (int i = 0; i < 10; i++)
            cyc(1, 0, mk("underflow_hold", 0, 1, 1, 0, 0, (i > 0) ? ufx(1'b1) : 1'b0));
        cyc(0, 0, mk("underflow_tail", 0, 1, 1, 0, 0, ufx(1'b1)));

        // Write pointer steps to Gray(3): visible two edges later.
        cyc(0, 10'd2, mk("wr3_edgeM", 0, 1, 1, 0, 0, 0));
        cyc(0, 10'd2, mk("wr3_edgeM1", 0, 1, 1, 0, 0, 0));
        cyc(0, 10'd2, mk("wr3_edgeM2", 0, 1, 1, 0, 0, 0));
        cyc(1, 10'd2, mk("rd_lvl3", 3, 0, 1, 1, 0, 0));
        cyc(1, 10'd2, mk("rd_lvl2", 2, 0, 1, 2, 1, 0));
        cyc(1, 10'd2, mk("rd_lvl1", 1, 0, 1, 3, 2, 0));
        cyc(1, 10'd2, mk("rd_empty_rej", 0, 1, 1, 3, 3, 0));
        cyc(0, 10'd2, mk("rd_empty_idle", 0, 1, 1, 3, 3, ufx(1'b1)));

        // Full FIFO, then drain to the almost-empty threshold.
        doReset();
        cyc(0, 10'h300, mk("full_sync0", 0, 1, 1, 0, 0, 0));
        cyc(0, 10'h300, mk("full_sync1", 0, 1, 1, 0, 0, 0));
        cyc(0, 10'h300, mk("full_sync2", 0, 1, 1, 0, 0, 0));
        for (int k = 0; k < 508; k++)
            cyc(1, 10'h300, mk("drain", 512 - k, 0, ((512 - k) <= 4) ? 1'b1 : 1'b0, k + 1, k, 0));
        cyc(0, 10'h300, mk("drain_ae", 4, 0, 1, 508, 508, 0));

        // Stream 1030 words across the pointer wrap with the writer just ahead.
        doReset();
        cyc(0, g(3), mk("stream_pre0", 0, 1, 1, 0, 0, 0));
        cyc(0, g(3), mk("stream_pre1", 0, 1, 1, 0, 0, 0));
        cyc(0, g(3), mk("stream_pre2", 0, 1, 1, 0, 0, 0));
        for (int j = 0; j < 1030; j++)
            cyc(1, g(4 + j), mk("stream", (j == 0) ? 3 : ((j == 1) ? 2 : 1), 0, 1, j + 1, j, 0));

        // Level 7 with an accept that coincides with a synced write, then reset mid-stream.
        doReset();
        cyc(0, g(7), mk("l7_sync0", 0, 1, 1, 0, 0, 0));
        cyc(0, g(7), mk("l7_sync1", 0, 1, 1, 0, 0, 0));
        cyc(0, g(7), mk("l7_sync2", 0, 1, 1, 0, 0, 0));
        cyc(0, g(8), mk("l7_reached", 7, 0, 0, 0, 0, 0));
        cyc(0, g(8), mk("l7_hold", 7, 0, 0, 0, 0, 0));
        cyc(1, g(8), mk("l7_rd_wr", 7, 0, 0, 1, 0, 0));
        cyc(0, g(8), mk("l7_unchanged", 7, 0, 0, 1, 1, 0));
        doReset();
        cyc(0, 0, mk("post_reset", 0, 1, 1, 0, 0, 0));

        repeat (2) @(negedge RD_CLK);
        if (sbQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
